// File: rtl/ft_pkg.sv
// Shared types for the lockstep recovery controller: FSM state encoding and
// the width of the total-error counter.
package ft_pkg;

   localparam int ERR_CNT_W = 8;

   typedef enum logic [2:0] {
      RUN,
      HALT,
      RESET,
      RESTORE,
      RESUME,
      FATAL
   } ft_rec_state_e;

endpackage

// File: rtl/ft_shadow_rf.sv
// Shadow copy of the architectural register file: one synchronous write port,
// one combinational read port, x0 reads as zero, cleared by reset.
module ft_shadow_rf #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en_i && (wr_addr_i != '0) && (32'(wr_addr_i) < NUM_REGS)) begin
         mem_d[wr_addr_i] = wr_data_i;
      end
   end

   // NOTE: the array is reset on purpose -- a reset mid-recovery must leave the
   // shadow reading all zeros, so this cannot be mapped to a RAM macro.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data_o = (32'(rd_addr_i) < NUM_REGS) ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: tracks approved commits in a shadow RF and a
// checkpoint PC, and on a comparator mismatch runs halt/reset/restore/resume.
module ft_recovery_ctrl
   import ft_pkg::*;
#(
   parameter int                       ADDR_WIDTH = 5,
   parameter int                       DATA_WIDTH = 32,
   parameter int                       NUM_REGS   = 32,
   parameter int                       RST_CYCLES = 4,
   parameter int                       MAX_RETRY  = 3,
   parameter logic [DATA_WIDTH-1:0]    BOOT_ADDR  = 32'h0000_0080
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_instr_i,
   input  logic                  error_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   output logic                  halt_o,
   output logic                  core_rst_o,
   output logic [DATA_WIDTH-1:0] boot_addr_o,
   output logic                  restore_we_o,
   output logic [ADDR_WIDTH-1:0] restore_addr_o,
   output logic [DATA_WIDTH-1:0] restore_data_o,
   output logic                  recovering_o,
   output logic                  fatal_o,
   output logic [ERR_CNT_W-1:0]  err_count_o
);

   localparam int RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int RETRY_W   = $clog2(MAX_RETRY + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

   ft_rec_state_e          state_q,    state_d;
   logic [RST_CNT_W-1:0]   rst_cnt_q,  rst_cnt_d;
   logic [ADDR_WIDTH-1:0]  rest_addr_q, rest_addr_d;
   logic [DATA_WIDTH-1:0]  ckpt_q,     ckpt_d;
   logic [RETRY_W-1:0]     retry_q,    retry_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q,  err_cnt_d;

   logic good_commit;
   logic bad_commit;

   // Comparator inputs only matter while the cores are actually running.
   assign good_commit = (state_q == RUN) && valid_instr_i && !error_i;
   assign bad_commit  = (state_q == RUN) && valid_instr_i &&  error_i;

   // NOTE: every output and _d signal gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      rest_addr_d  = rest_addr_q;
      ckpt_d       = ckpt_q;
      retry_d      = retry_q;
      err_cnt_d    = err_cnt_q;
      halt_o       = 1'b0;
      core_rst_o   = 1'b0;
      restore_we_o = 1'b0;
      fatal_o      = 1'b0;

      unique case (state_q)
         RUN: begin
            if (good_commit) begin
               ckpt_d  = pc_i + DATA_WIDTH'(4);
               retry_d = '0;
            end else if (bad_commit) begin
               err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
               retry_d   = retry_q + 1'b1;
               state_d   = (retry_d == RETRY_W'(MAX_RETRY)) ? FATAL : HALT;
            end
         end
         HALT: begin
            halt_o    = 1'b1;
            rst_cnt_d = RST_CNT_W'(RST_CYCLES - 1);
            state_d   = RESET;
         end
         RESET: begin
            halt_o     = 1'b1;
            core_rst_o = 1'b1;
            if (rst_cnt_q == '0) begin
               rest_addr_d = ADDR_WIDTH'(1);
               state_d     = RESTORE;
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end
         RESTORE: begin
            halt_o       = 1'b1;
            restore_we_o = 1'b1;
            if (rest_addr_q == LAST_ADDR) begin
               state_d = RESUME;
            end else begin
               rest_addr_d = rest_addr_q + 1'b1;
            end
         end
         RESUME: begin
            halt_o  = 1'b1;
            state_d = RUN;
         end
         FATAL: begin
            halt_o  = 1'b1;
            fatal_o = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of the others regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         rst_cnt_q   <= '0;
         rest_addr_q <= '0;
         ckpt_q      <= BOOT_ADDR;
         retry_q     <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         rest_addr_q <= rest_addr_d;
         ckpt_q      <= ckpt_d;
         retry_q     <= retry_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign restore_addr_o = restore_we_o ? rest_addr_q : '0;
   assign boot_addr_o    = ckpt_q;
   assign recovering_o   = (state_q != RUN);
   assign err_count_o    = err_cnt_q;

   ft_shadow_rf #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_shadow_rf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (good_commit && we_i),
      .wr_addr_i (addr_i),
      .wr_data_i (data_i),
      .rd_addr_i (restore_addr_o),
      .rd_data_o (restore_data_o)
   );

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl: recovery timing, shadow restore,
// ignored inputs during recovery, fatal escalation, PC wrap and async reset.
module tb_ft_recovery_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_instr_i;
   logic        error_i;
   logic        we_i;
   logic [4:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] pc_i;
   logic        halt_o;
   logic        core_rst_o;
   logic [31:0] boot_addr_o;
   logic        restore_we_o;
   logic [4:0]  restore_addr_o;
   logic [31:0] restore_data_o;
   logic        recovering_o;
   logic        fatal_o;
   logic [7:0]  err_count_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_shadow [32];

   always #5 clk_i = ~clk_i;

   ft_recovery_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_instr_i  (valid_instr_i),
      .error_i        (error_i),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .data_i         (data_i),
      .pc_i           (pc_i),
      .halt_o         (halt_o),
      .core_rst_o     (core_rst_o),
      .boot_addr_o    (boot_addr_o),
      .restore_we_o   (restore_we_o),
      .restore_addr_o (restore_addr_o),
      .restore_data_o (restore_data_o),
      .recovering_o   (recovering_o),
      .fatal_o        (fatal_o),
      .err_count_o    (err_count_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      valid_instr_i = 1'b0;
      error_i       = 1'b0;
      we_i          = 1'b0;
      addr_i        = '0;
      data_i        = '0;
      pc_i          = '0;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      clear_inputs();
      for (int i = 0; i < 32; i++) exp_shadow[i] = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic good_commit(input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] pc);
      valid_instr_i = 1'b1; error_i = 1'b0;
      we_i = we; addr_i = a; data_i = d; pc_i = pc;
      step();
      clear_inputs();
      if (we && a != 5'd0) exp_shadow[a] = d;
   endtask

   task automatic inject_error();
      valid_instr_i = 1'b1; error_i = 1'b1;
      step();
      clear_inputs();
   endtask

   // Walks cycles t+1..t+38 after an error at t and checks every cycle.
   task automatic run_recovery(input logic [31:0] exp_boot, input logic [7:0] exp_err,
                               input bit noise);
      logic [4:0]  exp_ctl, obs_ctl;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      for (int k = 1; k <= 38; k++) begin
         if (k > 1) begin
            step();
            clear_inputs();
         end
         exp_ctl  = {k <= 37, (k >= 2 && k <= 5), (k >= 6 && k <= 36), k <= 37, 1'b0};
         obs_ctl  = {halt_o, core_rst_o, restore_we_o, recovering_o, fatal_o};
         exp_addr = (k >= 6 && k <= 36) ? 5'(k - 5) : 5'd0;
         exp_data = exp_shadow[exp_addr];
         checks++;
         if (obs_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL recov_ctl k=%0d got=%b want=%b (halt,core_rst,we,recovering,fatal)",
                     k, obs_ctl, exp_ctl);
         end
         checks++;
         if (restore_addr_o !== exp_addr || restore_data_o !== exp_data) begin
            errors++;
            $display("FAIL recov_restore k=%0d got addr=%0d data=%h want addr=%0d data=%h",
                     k, restore_addr_o, restore_data_o, exp_addr, exp_data);
         end
         checks++;
         if (boot_addr_o !== exp_boot) begin
            errors++;
            $display("FAIL recov_boot k=%0d got=%h want=%h", k, boot_addr_o, exp_boot);
         end
         if (noise && (k == 3 || k == 20)) begin
            valid_instr_i = 1'b1; error_i = 1'b1;
            we_i = 1'b1; addr_i = 5'd7; data_i = 32'hBAD0_BAD0; pc_i = 32'h9990;
         end
      end
      checks++;
      if (err_count_o !== exp_err) begin
         errors++;
         $display("FAIL recov_err_count got=%0d want=%0d", err_count_o, exp_err);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({halt_o, core_rst_o, restore_we_o, recovering_o, fatal_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl got=%b want=00000",
                  {halt_o, core_rst_o, restore_we_o, recovering_o, fatal_o});
      end
      checks++;
      if (boot_addr_o !== 32'h80 || err_count_o !== 8'd0) begin
         errors++;
         $display("FAIL reset_vals got boot=%h err=%0d want boot=00000080 err=0",
                  boot_addr_o, err_count_o);
      end
   endtask

   task automatic test_basic_recovery();
      good_commit(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h100);
      good_commit(1'b1, 5'd0, 32'h1234, 32'h104);
      checks++;
      if (boot_addr_o !== 32'h108) begin
         errors++;
         $display("FAIL ckpt_update got=%h want=00000108", boot_addr_o);
      end
      inject_error();
      run_recovery(32'h108, 8'd1, 1'b0);
   endtask

   task automatic test_ignore_during_recovery();
      good_commit(1'b1, 5'd3, 32'hA5A5_A5A5, 32'h200);
      inject_error();
      run_recovery(32'h204, 8'd2, 1'b1);
   endtask

   task automatic test_back_to_back();
      good_commit(1'b0, 5'd0, 32'h0, 32'h300);
      inject_error();
      run_recovery(32'h304, 8'd3, 1'b0);
      inject_error();
      run_recovery(32'h304, 8'd4, 1'b0);
      inject_error();
      valid_instr_i = 1'b1; we_i = 1'b1; addr_i = 5'd9; data_i = 32'hFFFF; pc_i = 32'h400;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({halt_o, core_rst_o, restore_we_o, fatal_o} !== 4'b1001) begin
            errors++;
            $display("FAIL fatal_ctl c=%0d got=%b want=1001 (halt,core_rst,we,fatal)",
                     c, {halt_o, core_rst_o, restore_we_o, fatal_o});
         end
         checks++;
         if (err_count_o !== 8'd5 || boot_addr_o !== 32'h304) begin
            errors++;
            $display("FAIL fatal_vals c=%0d got err=%0d boot=%h want err=5 boot=00000304",
                     c, err_count_o, boot_addr_o);
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_pc_wrap();
      apply_reset();
      good_commit(1'b0, 5'd0, 32'h0, 32'hFFFF_FFFC);
      checks++;
      if (boot_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL pc_wrap got=%h want=00000000", boot_addr_o);
      end
      inject_error();
      run_recovery(32'h0, 8'd1, 1'b0);
   endtask

   task automatic test_reset_mid_restore();
      apply_reset();
      good_commit(1'b1, 5'd10, 32'h1111_2222, 32'h500);
      inject_error();
      repeat (14) step();
      checks++;
      if (restore_we_o !== 1'b1 || restore_addr_o !== 5'd10 || restore_data_o !== 32'h1111_2222) begin
         errors++;
         $display("FAIL mid_restore got we=%b addr=%0d data=%h want we=1 addr=10 data=11112222",
                  restore_we_o, restore_addr_o, restore_data_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if ({halt_o, core_rst_o, restore_we_o, recovering_o, fatal_o} !== 5'b0 ||
          boot_addr_o !== 32'h80 || err_count_o !== 8'd0 ||
          restore_addr_o !== 5'd0 || restore_data_o !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got ctl=%b boot=%h err=%0d addr=%0d data=%h want 0/00000080/0/0/0",
                  {halt_o, core_rst_o, restore_we_o, recovering_o, fatal_o},
                  boot_addr_o, err_count_o, restore_addr_o, restore_data_o);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      for (int i = 0; i < 32; i++) exp_shadow[i] = '0;
      inject_error();
      run_recovery(32'h80, 8'd1, 1'b0);
   endtask

   initial begin
      rst_i = 1'b1;
      clear_inputs();
      test_reset();
      test_basic_recovery();
      test_ignore_during_recovery();
      test_back_to_back();
      test_pc_wrap();
      test_reset_mid_restore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ft_recovery_ctrl.md
Name: ft_recovery_ctrl

Overview:
- Lockstep recovery controller for the dual-core fault-tolerant pair, fed directly by the lane comparator (error, valid, committed addr/data).
- Keeps a shadow register file of comparator-approved writes and a checkpoint PC.
- On a mismatch it halts both cores, pulses core reset, rewrites both register files from the shadow copy, then resumes at the checkpoint. Repeated failures escalate to a sticky fatal state.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data and PC width.
- NUM_REGS, 32, architectural registers; x0 is never restored.
- RST_CYCLES, 4, core reset pulse length in cycles (must be ≥1).
- MAX_RETRY, 3, consecutive failed recoveries before fatal (must be ≥1).
- BOOT_ADDR, 32'h0000_0080, checkpoint PC value after reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- valid_instr_i  in  1  comparator compare is valid this cycle
- error_i  in  1  comparator mismatch
- we_i  in  1  committed write enable (lane A)
- addr_i  in  ADDR_WIDTH  committed write address
- data_i  in  DATA_WIDTH  committed write data
- pc_i  in  DATA_WIDTH  PC of the committed instruction
- halt_o  out  1  stall both cores
- core_rst_o  out  1  reset both cores
- boot_addr_o  out  DATA_WIDTH  resume PC (checkpoint)
- restore_we_o  out  1  regfile restore write strobe (both cores)
- restore_addr_o  out  ADDR_WIDTH  restore address
- restore_data_o  out  DATA_WIDTH  restore data
- recovering_o  out  1  high in any state except RUN
- fatal_o  out  1  sticky unrecoverable fault
- err_count_o  out  8  total errors detected, saturating at 255

Behaviour:
- Reset values: state RUN; all outputs 0 except boot_addr_o = BOOT_ADDR; shadow RF all 0; checkpoint = BOOT_ADDR; consecutive-failure counter 0.
- Good commit: state RUN, valid_instr_i=1, error_i=0.
  - Checkpoint ← pc_i + 4, mod 2^DATA_WIDTH; wrap-around allowed.
  - If we_i=1 and addr_i≠0: shadow[addr_i] ← data_i.
  - Consecutive-failure counter clears.
  - All updates registered, visible the next cycle.
- Error: state RUN, valid_instr_i=1, error_i=1, at cycle t.
  - No shadow or checkpoint update.
  - err_count_o increments, saturating.
  - Consecutive counter increments.
  - Next state at t+1: FATAL if the incremented consecutive count equals MAX_RETRY, otherwise HALT.
- valid_instr_i=0: inputs ignored.
- Inputs outside RUN: all comparator inputs ignored; no counting, no shadow writes.
- FSM, one state per cycle unless stated:
  - RUN: halt_o=0.
  - HALT: halt_o=1 for 1 cycle → RESET.
  - RESET: halt_o=1, core_rst_o=1 for exactly RST_CYCLES cycles (down-counter) → RESTORE.
  - RESTORE: halt_o=1, restore_we_o=1. restore_addr_o steps 1,2,…,NUM_REGS-1, one per cycle; restore_data_o = shadow[restore_addr_o], combinational read. After address NUM_REGS-1 → RESUME. Duration is NUM_REGS-1 cycles.
  - RESUME: halt_o=1, boot_addr_o = checkpoint for 1 cycle → RUN, where halt_o drops.
  - FATAL: halt_o=1, fatal_o=1. Core reset is not asserted. Exit only via rst_i.
- boot_addr_o is registered and always equals the current checkpoint; it is stable throughout recovery.
- Consecutive counter is not cleared by completing a recovery, only by a good commit. Back-to-back errors with no good commit between them therefore reach FATAL.
- Reset mid-recovery: asynchronous return to reset values. Shadow contents are lost (cleared).
- Error-to-resume latency in cycles: 1 + RST_CYCLES + (NUM_REGS-1) + 1; for the defaults 1+4+31+1 = 37.

Decomposition:
- Package ft_pkg holds:
  - state enum ft_rec_state_e {RUN, HALT, RESET, RESTORE, RESUME, FATAL};
  - localparam for err_count width (8).
- Sub-module ft_shadow_rf:
  - NUM_REGS×DATA_WIDTH flops;
  - 1 synchronous write port, x0 hardwired to 0;
  - 1 combinational read port;
  - asynchronous active-high clear.
- Controller FSM, counters and checkpoint stay in ft_recovery_ctrl.

Test Plan:
1. Reset release → halt_o=0, boot_addr_o=32'h80, err_count_o=0, fatal_o=0, restore_we_o=0.
2. Good commits (we=1, addr=5, data=32'hDEAD_BEEF, pc=32'h100), then (addr=0, data=32'h1234, pc=32'h104); then error at t.
   - Required: halt_o=1 at t+1; core_rst_o high t+2..t+5.
   - restore_we_o high t+6..t+36, with addr 5 → data 32'hDEAD_BEEF and all other addresses 0.
   - boot_addr_o=32'h108; halt_o=0 at t+38; err_count_o=1.
3. Error pulses during RESTORE and during RESET → ignored: err_count_o unchanged, sequence timing unchanged.
4. Three errors, each at the first valid compare after resume, with no good commit → third error enters FATAL: fatal_o=1, halt_o=1 held, err_count_o=3. A following good commit has no effect.
5. Good commit with pc_i=32'hFFFF_FFFC → checkpoint wraps to 32'h0; the subsequent error recovery resumes at boot_addr_o=0.
6. Assert rst_i during RESTORE (addr=10) → outputs return to reset values immediately; shadow reads 0; boot_addr_o=32'h80.
